// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four-bank word memory that answers cache fill/writeback traffic.
// Each bank has its own busy counter; reads return through a fixed-latency pipeline.
module banked_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int BANK_CYCLES = 4,
    parameter int READ_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [15:0]       data_out,
    output logic              data_valid,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);
    localparam int CW    = $clog2(BANK_CYCLES + 1);
    localparam int WORDS = 2 ** (ADDR_W - 1);

    logic [15:0]         mem_q [WORDS];
    logic [CW-1:0]       cnt_q [4];
    logic [CW-1:0]       cnt_d [4];
    logic [READ_LAT-1:0] vld_q;
    logic [READ_LAT-1:0] vld_d;
    logic [15:0]         dat_q [READ_LAT];
    logic [15:0]         dat_d [READ_LAT];
    logic [1:0]          bank;
    logic [ADDR_W-2:0]   widx;
    logic                one_req;
    logic                acc;
    logic                acc_rd;
    logic                acc_wr;

    assign bank    = addr[2:1];
    assign widx    = addr[ADDR_W-1:1];
    assign one_req = rd ^ wr;
    assign err     = (rd & wr) | ((rd | wr) & addr[0]);
    assign stall   = one_req & ~addr[0] & busy[bank];
    assign acc     = one_req & ~err & ~stall;
    assign acc_rd  = acc & rd;
    assign acc_wr  = acc & wr;

    // Counter reloads on accept, otherwise drains to zero and sits there.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            busy[b]  = (cnt_q[b] != '0);
            cnt_d[b] = cnt_q[b];
            if (acc && (bank == 2'(b))) begin
                cnt_d[b] = CW'(BANK_CYCLES);
            end else if (busy[b]) begin
                cnt_d[b] = cnt_q[b] - CW'(1);
            end
        end
    end

    // Data only moves with its valid bit, so the last stage holds the last read.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = acc_rd;
        dat_d[0] = acc_rd ? mem_q[widx] : dat_q[0];
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= '0;
            end
            vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            vld_q <= vld_d;
            for (int i = 0; i < READ_LAT; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Storage survives reset.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            mem_q[widx] <= data_in;
        end
    end

    assign data_out   = dat_q[READ_LAT-1];
    assign data_valid = vld_q[READ_LAT-1];

endmodule

// File: tb/tb_banked_mem_responder.sv
// tb_banked_mem_responder: directed scenarios plus a random rd/wr mix,
// checked cycle by cycle against a bank-timing and read-queue model.
module tb_banked_mem_responder;
    localparam int ADDR_W      = 16;
    localparam int BANK_CYCLES = 4;
    localparam int READ_LAT    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [15:0]       data_in = '0;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic [15:0]       data_out;
    logic              data_valid;
    logic              stall;
    logic [3:0]        busy;
    logic              err;

    banked_mem_responder #(
        .ADDR_W(ADDR_W),
        .BANK_CYCLES(BANK_CYCLES),
        .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .data_in(data_in),
        .wr(wr),
        .rd(rd),
        .data_out(data_out),
        .data_valid(data_valid),
        .stall(stall),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    typedef struct {
        int          due;
        logic [15:0] d;
        bit          known;
    } rd_t;

    int          cyc = 0;
    int          free_at[4];
    logic [15:0] mdl[int];
    rd_t         rq[$];
    logic [15:0] last_d = '0;
    bit          last_known = 1'b1;

    logic        o_stall, o_err, o_dv;
    logic [15:0] o_dout;
    logic [3:0]  o_busy;

    // One request cycle; called just after a falling edge.
    task automatic step(input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] d);
        bit e, s, acc;
        int b, idx;
        logic [3:0] eb;
        rd_t ent;
        rd = r; wr = w; addr = a; data_in = d;
        #1;
        b = int'(a[2:1]);
        idx = int'(a[15:1]);
        for (int i = 0; i < 4; i++) eb[i] = (cyc < free_at[i]);
        e = (r && w) || ((r || w) && a[0]);
        s = (r ^ w) && !a[0] && eb[b];
        acc = (r ^ w) && !e && !s;
        chk("err", 32'(err), 32'(e));
        chk("stall", 32'(stall), 32'(s));
        chk("busy", 32'(busy), 32'(eb));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("data_valid", 32'(data_valid), 32'd1);
            if (rq[0].known) chk("data_out", 32'(data_out), 32'(rq[0].d));
            last_d = rq[0].d;
            last_known = rq[0].known;
            void'(rq.pop_front());
        end else begin
            chk("data_valid_idle", 32'(data_valid), 32'd0);
            if (last_known) chk("data_out_hold", 32'(data_out), 32'(last_d));
        end
        o_stall = stall; o_err = err; o_dv = data_valid;
        o_dout = data_out; o_busy = busy;
        @(posedge clk);
        if (acc) begin
            free_at[b] = cyc + BANK_CYCLES + 1;
            if (w) begin
                mdl[idx] = d;
            end else begin
                ent.due = cyc + READ_LAT;
                ent.known = mdl.exists(idx);
                ent.d = ent.known ? mdl[idx] : 16'h0;
                rq.push_back(ent);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic pulse_reset();
        rd = 1'b0; wr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rq.delete();
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        last_d = '0;
        last_known = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] dvs;
        bit h_r, h_w;
        logic [15:0] h_a, h_d;
        int pick;
        for (int i = 0; i < 4; i++) free_at[i] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_dv", 32'(data_valid), 32'd0);
        chk("init_dout", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write, idle, read back with latency and hold
        step(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        idle(5);
        step(1'b1, 1'b0, 16'h0010, 16'h0);
        chk("t1_stall", 32'(o_stall), 32'd0);
        idle(1);
        chk("t1_early", 32'(o_dv), 32'd0);
        idle(1);
        chk("t1_dv", 32'(o_dv), 32'd1);
        chk("t1_data", 32'(o_dout), 32'hBEEF);
        idle(3);
        chk("t1_hold_dv", 32'(o_dv), 32'd0);
        chk("t1_hold", 32'(o_dout), 32'hBEEF);

        // 2: same-bank conflict held off for BANK_CYCLES cycles
        idle(5);
        step(1'b1, 1'b0, 16'h0000, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 16'h0008, 16'h0);
            chk("t2_stall", 32'(o_stall), 32'd1);
            chk("t2_busy0", 32'(o_busy[0]), 32'd1);
        end
        step(1'b1, 1'b0, 16'h0008, 16'h0);
        chk("t2_accept", 32'(o_stall), 32'd0);

        // 3: four-word line fill across all banks
        idle(5);
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b1, 16'(16'h0040 + 2 * k), 16'(16'hA000 + k));
        idle(5);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 16'(16'h0040 + 2 * k), 16'h0);
            chk("t3_nostall", 32'(o_stall), 32'd0);
            if (k >= 2) dvs[k-2] = o_dv;
        end
        step(1'b0, 1'b0, 16'h0, 16'h0);
        chk("t3_busy", 32'(o_busy), 32'hF);
        dvs[2] = o_dv;
        idle(1);
        dvs[3] = o_dv;
        chk("t3_dv", 32'(dvs), 32'hF);
        chk("t3_last", 32'(o_dout), 32'hA003);

        // 4: illegal requests are ignored
        idle(5);
        step(1'b0, 1'b1, 16'h0020, 16'h5A5A);
        idle(5);
        step(1'b1, 1'b1, 16'h0020, 16'hFFFF);
        chk("t4_err_rw", 32'(o_err), 32'd1);
        chk("t4_stall_rw", 32'(o_stall), 32'd0);
        step(1'b0, 1'b1, 16'h0021, 16'h1111);
        chk("t4_err_odd", 32'(o_err), 32'd1);
        chk("t4_stall_odd", 32'(o_stall), 32'd0);
        step(1'b1, 1'b0, 16'h0020, 16'h0);
        chk("t4_busy", 32'(o_busy), 32'd0);
        idle(2);
        chk("t4_data", 32'(o_dout), 32'h5A5A);

        // 5: reset drops an in-flight read, storage survives
        idle(5);
        step(1'b0, 1'b1, 16'h0030, 16'h1234);
        idle(5);
        step(1'b1, 1'b0, 16'h0030, 16'h0);
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("t5_no_dv", 32'(o_dv), 32'd0);
        end
        step(1'b1, 1'b0, 16'h0030, 16'h0);
        idle(2);
        chk("t5_data", 32'(o_dout), 32'h1234);

        // 6: random mix over 256 words, requester holds while stalled
        idle(5);
        h_r = 0; h_w = 0; h_a = 0; h_d = 0;
        for (int n = 0; n < 600; n++) begin
            if (!(o_stall && n > 0)) begin
                pick = int'($urandom_range(0, 99));
                h_a = {7'b0, 8'($urandom), 1'b0};
                h_d = 16'($urandom);
                h_r = 0; h_w = 0;
                if (pick < 10) begin
                    h_r = 0; h_w = 0;
                end else if (pick < 13) begin
                    h_r = 1; h_w = 1;
                end else if (pick < 16) begin
                    h_w = 1; h_a[0] = 1'b1;
                end else if (pick < 55) begin
                    h_w = 1;
                end else begin
                    h_r = 1;
                end
            end
            step(h_r, h_w, h_a, h_d);
        end
        idle(READ_LAT + 2);
        chk("t6_drained", 32'(rq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
